// File: rtl/rr_mux_nway_if.sv
// rtl/rr_mux_nway_if.sv - handshake bundle between N producers, the arbiter and one consumer
interface rr_mux_nway_if #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/rr_mux_nway.sv
// rtl/rr_mux_nway.sv - N-way round-robin / forced-select mux with a single registered output slot
module rr_mux_nway #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic           clock_i,
  input  logic           reset_n_i,
  rr_mux_nway_if.slave   bus
);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             load_en;
  logic             grant_found;
  logic [SELW-1:0]  grant_idx;
  logic [N-1:0]     grant_oh;
  logic [WIDTH-1:0] grant_data;
  int               idx;

  assign load_en = !out_valid_q || bus.out_ready;

  // Grant search: circular scan from ptr in round-robin, exact match on sel when forced.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (!bus.mode) begin
      for (int off = 0; off < N; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= N) idx = idx - N;
        if (!grant_found && bus.in_valid[idx]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      grant_oh[i] = grant_found && (grant_idx == SELW'(i));
      if (grant_oh[i]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Reset must also block acceptance, or a producer would lose a word the register never takes.
  assign bus.in_ready = (load_en && reset_n_i) ? grant_oh : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (grant_found) begin
        out_data_d  = grant_data;
        out_chan_d  = grant_idx;
        out_valid_d = 1'b1;
        ptr_d       = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_nway.sv
// tb/tb_rr_mux_nway.sv - directed-vector bench for rr_mux_nway at N=8 and N=6
module tb_rr_mux_nway;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  rr_mux_nway_if #(.WIDTH(16), .N(8)) bus8 ();
  rr_mux_nway_if #(.WIDTH(16), .N(6)) bus6 ();

  rr_mux_nway #(.WIDTH(16), .N(8)) dut8 (
    .clock_i   (clk),
    .reset_n_i (reset_n),
    .bus       (bus8.slave)
  );

  rr_mux_nway #(.WIDTH(16), .N(6)) dut6 (
    .clock_i   (clk),
    .reset_n_i (reset_n),
    .bus       (bus6.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus8.in_valid = 8'hFF;
    tick();
    tick();
    if (bus8.out_valid !== 1'b0) begin $display("FAIL reset_out_valid got=%0b exp=0", bus8.out_valid); n_fail++; end
    n_checks++;
    if (bus8.out_data !== 16'h0) begin $display("FAIL reset_out_data got=%h exp=0000", bus8.out_data); n_fail++; end
    n_checks++;
    if (bus8.out_chan !== 3'd0) begin $display("FAIL reset_out_chan got=%0d exp=0", bus8.out_chan); n_fail++; end
    n_checks++;
    if (bus8.in_ready !== 8'h00) begin $display("FAIL reset_in_ready got=%h exp=00", bus8.in_ready); n_fail++; end
    n_checks++;
    if (bus6.out_valid !== 1'b0) begin $display("FAIL reset6_out_valid got=%0b exp=0", bus6.out_valid); n_fail++; end
    n_checks++;
  endtask

  task automatic test_single();
    reset_n = 1'b1;
    bus8.out_ready = 1'b1;
    bus8.mode = 1'b0;
    bus8.in_valid = 8'b0000_0100;
    bus8.in_data[2*16 +: 16] = 16'hBEEF;
    #1;
    if (bus8.in_ready !== 8'b0000_0100) begin $display("FAIL single_in_ready got=%h exp=04", bus8.in_ready); n_fail++; end
    n_checks++;
    tick();
    bus8.in_valid = 8'h00;
    if (bus8.out_valid !== 1'b1) begin $display("FAIL single_out_valid got=%0b exp=1", bus8.out_valid); n_fail++; end
    n_checks++;
    if (bus8.out_data !== 16'hBEEF) begin $display("FAIL single_out_data got=%h exp=beef", bus8.out_data); n_fail++; end
    n_checks++;
    if (bus8.out_chan !== 3'd2) begin $display("FAIL single_out_chan got=%0d exp=2", bus8.out_chan); n_fail++; end
    n_checks++;
    tick();
    if (bus8.out_valid !== 1'b0) begin $display("FAIL single_drain_valid got=%0b exp=0", bus8.out_valid); n_fail++; end
    n_checks++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 8; i++) bus8.in_data[i*16 +: 16] = 16'(16'h1000 + i);
    bus8.in_valid = 8'hFF;
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus8.out_valid !== 1'b1) begin $display("FAIL rr_valid step=%0d got=%0b exp=1", k, bus8.out_valid); n_fail++; end
      n_checks++;
      if (bus8.out_chan !== 3'(k % 8)) begin $display("FAIL rr_chan step=%0d got=%0d exp=%0d", k, bus8.out_chan, k % 8); n_fail++; end
      n_checks++;
      if (bus8.out_data !== 16'(16'h1000 + (k % 8))) begin $display("FAIL rr_data step=%0d got=%h exp=%h", k, bus8.out_data, 16'(16'h1000 + (k % 8))); n_fail++; end
      n_checks++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus8.in_valid = 8'hFF;
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus8.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus8.in_ready !== 8'h00) begin $display("FAIL bp_in_ready cyc=%0d got=%h exp=00", k, bus8.in_ready); n_fail++; end
      n_checks++;
      tick();
      if (bus8.out_data !== 16'h1003) begin $display("FAIL bp_hold_data cyc=%0d got=%h exp=1003", k, bus8.out_data); n_fail++; end
      n_checks++;
      if (bus8.out_chan !== 3'd3) begin $display("FAIL bp_hold_chan cyc=%0d got=%0d exp=3", k, bus8.out_chan); n_fail++; end
      n_checks++;
      if (bus8.out_valid !== 1'b1) begin $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", k, bus8.out_valid); n_fail++; end
      n_checks++;
    end
    bus8.out_ready = 1'b1;
    #1;
    if (bus8.in_ready !== 8'h10) begin $display("FAIL bp_release_in_ready got=%h exp=10", bus8.in_ready); n_fail++; end
    n_checks++;
    tick();
    if (bus8.out_chan !== 3'd4 || bus8.out_data !== 16'h1004) begin
      $display("FAIL bp_release_load got chan=%0d data=%h exp chan=4 data=1004", bus8.out_chan, bus8.out_data); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_forced();
    do_reset();
    bus8.mode = 1'b1;
    bus8.sel = 3'd5;
    bus8.in_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus8.in_ready !== 8'h20) begin $display("FAIL forced_in_ready cyc=%0d got=%h exp=20", k, bus8.in_ready); n_fail++; end
      n_checks++;
      tick();
      if (bus8.out_chan !== 3'd5 || bus8.out_data !== 16'h1005) begin
        $display("FAIL forced_out cyc=%0d got chan=%0d data=%h exp chan=5 data=1005", k, bus8.out_chan, bus8.out_data); n_fail++;
      end
      n_checks++;
    end
    bus8.mode = 1'b0;
    #1;
    if (bus8.in_ready !== 8'h40) begin $display("FAIL forced_resume_in_ready got=%h exp=40", bus8.in_ready); n_fail++; end
    n_checks++;
    tick();
    if (bus8.out_chan !== 3'd6) begin $display("FAIL forced_resume_chan got=%0d exp=6", bus8.out_chan); n_fail++; end
    n_checks++;
    bus8.mode = 1'b1;
    bus8.sel = 3'd3;
    bus8.in_valid = 8'hF7;
    #1;
    if (bus8.in_ready !== 8'h00) begin $display("FAIL forced_nogrant_in_ready got=%h exp=00", bus8.in_ready); n_fail++; end
    n_checks++;
    tick();
    if (bus8.out_valid !== 1'b0) begin $display("FAIL forced_nogrant_valid got=%0b exp=0", bus8.out_valid); n_fail++; end
    n_checks++;
    if (bus8.out_chan !== 3'd6) begin $display("FAIL forced_nogrant_chan_hold got=%0d exp=6", bus8.out_chan); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    bus8.mode = 1'b0;
    bus8.in_valid = 8'h04;
    tick();
    if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd2) begin
      $display("FAIL mid_preload got valid=%0b chan=%0d exp valid=1 chan=2", bus8.out_valid, bus8.out_chan); n_fail++;
    end
    n_checks++;
    bus8.in_valid = 8'hFF;
    reset_n = 1'b0;
    #1;
    if (bus8.in_ready !== 8'h00) begin $display("FAIL mid_in_ready got=%h exp=00", bus8.in_ready); n_fail++; end
    n_checks++;
    tick();
    if (bus8.out_valid !== 1'b0 || bus8.out_chan !== 3'd0 || bus8.out_data !== 16'h0) begin
      $display("FAIL mid_cleared got valid=%0b chan=%0d data=%h exp 0/0/0000", bus8.out_valid, bus8.out_chan, bus8.out_data); n_fail++;
    end
    n_checks++;
    reset_n = 1'b1;
    bus8.in_valid = 8'h12;
    #1;
    if (bus8.in_ready !== 8'h02) begin $display("FAIL mid_first_grant got=%h exp=02", bus8.in_ready); n_fail++; end
    n_checks++;
    tick();
    if (bus8.out_chan !== 3'd1 || bus8.out_data !== 16'h1001) begin
      $display("FAIL mid_first_out got chan=%0d data=%h exp chan=1 data=1001", bus8.out_chan, bus8.out_data); n_fail++;
    end
    n_checks++;
    bus8.in_valid = 8'h00;
  endtask

  task automatic test_non_pow2();
    do_reset();
    for (int i = 0; i < 6; i++) bus6.in_data[i*16 +: 16] = 16'(16'h2000 + i);
    bus6.in_valid = 6'h3F;
    bus6.out_ready = 1'b1;
    bus6.mode = 1'b1;
    for (int s = 6; s < 8; s++) begin
      bus6.sel = 3'(s);
      #1;
      if (bus6.in_ready !== 6'h00) begin $display("FAIL np2_sel_in_ready sel=%0d got=%h exp=00", s, bus6.in_ready); n_fail++; end
      n_checks++;
      tick();
      if (bus6.out_valid !== 1'b0) begin $display("FAIL np2_sel_valid sel=%0d got=%0b exp=0", s, bus6.out_valid); n_fail++; end
      n_checks++;
    end
    bus6.mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (bus6.out_valid !== 1'b1 || bus6.out_chan !== 3'(k % 6) || bus6.out_data !== 16'(16'h2000 + (k % 6))) begin
        $display("FAIL np2_rr step=%0d got valid=%0b chan=%0d data=%h exp chan=%0d data=%h",
                 k, bus6.out_valid, bus6.out_chan, bus6.out_data, k % 6, 16'(16'h2000 + (k % 6)));
        n_fail++;
      end
      n_checks++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus8.in_data = '0;
    bus8.in_valid = '0;
    bus8.mode = 1'b0;
    bus8.sel = '0;
    bus8.out_ready = 1'b0;
    bus6.in_data = '0;
    bus6.in_valid = '0;
    bus6.mode = 1'b0;
    bus6.sel = '0;
    bus6.out_ready = 1'b1;

    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_forced();
    test_reset_mid();
    test_non_pow2();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_nway.md
Name: rr_mux_nway

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshakes on every input and on the output.
- It generalises the combinational Mux4Way16/Mux8Way16 family in three ways: a registered output stage, round-robin arbitration among requesting channels, and a forced-select mode that reproduces classic sel-driven MuxNWay behaviour.
- It sits between multiple producers and a single shared consumer, for example several register-file or memory read sources feeding one bus.

Parameters:
- WIDTH, 16, data width per channel.
- N, 8, number of input channels; legal range 2..16.
- SELW, $clog2(N) (3), derived width of sel, out_chan and the internal pointer; not to be overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; one-hot or all-zero.
- mode  input  1  0 = round-robin; 1 = forced select by sel.
- sel  input  SELW  channel index used when mode=1.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_chan hold a valid word.
- out_ready  input  1  consumer accepts.

Behaviour:
- Reset: reset_n=0 sampled at a clock edge clears out_valid, out_data, out_chan and ptr to 0. A reset in mid-transfer discards the held word; no in_ready is asserted while reset_n=0.
- Output register: single entry.
  - load_en = !out_valid || out_ready.
  - Output transfer occurs when out_valid && out_ready.
- Grant is combinational from the current inputs, ptr, mode and sel, so a mode or sel change takes effect in the same cycle.
  - mode=0: the lowest i in the circular order ptr, ptr+1, ..., ptr+N-1 (mod N) with in_valid[i]=1.
  - mode=1: channel sel if sel<N and in_valid[sel]=1; otherwise no grant. Other channels are never granted in this mode.
- in_ready[i] = load_en && grant[i]. Input transfer on channel i occurs when in_valid[i] && in_ready[i].
  - in_ready must not depend on out_valid except through load_en; a producer may hold in_valid while waiting.
- On an input transfer from channel k:
  - out_data <= in_data[k], out_chan <= k, out_valid <= 1 at the next edge. Latency is 1 cycle.
  - ptr <= (k+1) mod N. The pointer also updates in mode 1, so a return to mode 0 resumes fairly.
- If load_en=1 and there is no grant: out_valid <= 0; out_data and out_chan keep their old values.
- If load_en=0: all outputs hold. out_data and out_chan must be stable while out_valid && !out_ready.
- Simultaneous output drain and new input acceptance in one cycle is required. Sustained throughput is 1 word per cycle.
- Fairness: with all N channels continuously valid in mode 0, each channel is granted exactly once per N consecutive transfers.
- Wrap: ptr wraps from N-1 to 0, and the wrap is correct for non-power-of-2 N (e.g. N=6: ptr 5 -> 0).
- Protocol assumption on producers: once in_valid[i] is asserted it holds with stable in_data until accepted. The block does not check this.

Test Plan:
- Reset and single-channel transfer:
  - Stimulus: reset_n=0 for 2 cycles; expect out_valid=0, out_data=0, out_chan=0, in_ready=0.
  - Then raise reset_n, hold out_ready=1, drive in_valid=8'b0000_0100 with channel 2 data 16'hBEEF.
  - Required response: in_ready=8'b0000_0100 in the same cycle; next cycle out_valid=1, out_data=16'hBEEF, out_chan=2.
- Full contention, round-robin: mode=0, all in_valid=1, channel i data = 16'h1000+i, out_ready=1 -> out_chan sequence 0,1,...,7,0,1 on consecutive cycles, out_data matching each index, no bubbles.
- Backpressure:
  - Stimulus: out_valid=1 holding 16'h1003, out_ready=0 for 3 cycles.
  - Required response: in_ready=0, and out_data/out_chan unchanged for all 3 cycles.
  - Then out_ready=1: drain and the next load (channel 4) occur in the same cycle.
- Forced mode:
  - Stimulus: mode=1, sel=5, in_valid=8'hFF.
  - Required response: only channel 5 is granted, every cycle. After switching to mode=0, the next grant is channel 6 (ptr=6).
  - With sel=3 and in_valid[3]=0: in_ready=0 and out_valid drops to 0 after the drain.
- Non-power-of-2 (N=6, SELW=3):
  - Stimulus: mode=1 with sel=6 or 7.
  - Required response: no grant.
  - Stimulus: mode=0 with all channels valid.
  - Required response: sequence 0..5,0 (wrap 5->0).
- Reset mid-operation: drop reset_n while out_valid=1 and inputs are valid -> next cycle out_valid=0, ptr=0. After release, the first grant goes to the lowest valid channel from 0.
